// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero flagged alongside done.
//
// state | meaning
// IDLE  | waiting for start; result registers hold last values
// RUN   | one restoring iteration per edge (or zero-divisor exit)
// DONE  | one-cycle done pulse; a start here is accepted immediately
module seq_divider #(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Width-1:0] dividend,
    input  logic [Width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] quotient,
    output logic [Width-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CntW = $clog2(Width);
    localparam logic [CntW-1:0] LastIter = CntW'(Width - 1);

    state_t           state_q, state_d;
    logic [Width-1:0] rem_q, rem_d;
    logic [Width-1:0] work_q, work_d;
    logic [Width-1:0] dsr_q, dsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [Width-1:0] quotient_q, quotient_d;
    logic [Width-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // The partial remainder never exceeds Width bits after restore; the
    // extra bit exists only in the trial subtraction, as its sign.
    logic [Width:0]   rem_shift;
    logic [Width:0]   trial;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        work_d      = work_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        rem_shift = {rem_q, work_q[Width-1]};
        trial     = rem_shift - {1'b0, dsr_q};

        case (state_q)
            IDLE, DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    work_d  = dividend;
                    dsr_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dsr_q == '0) begin
                    // work_q still holds the untouched dividend here
                    quotient_d  = '1;
                    remainder_d = work_q;
                    dbz_d       = 1'b1;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    if (!trial[Width]) begin
                        rem_d  = trial[Width-1:0];
                        work_d = {work_q[Width-2:0], 1'b1};
                    end else begin
                        rem_d  = rem_shift[Width-1:0];
                        work_d = {work_q[Width-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        quotient_d  = work_d;
                        remainder_d = rem_d;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            work_q      <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            work_q      <= work_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
